hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Stall/flush side of the pipeline's hazard logic; the forwarding unit resolves the hazards it can, and this block handles the rest.
- Detects the hazards forwarding cannot cover: load-use, branch-in-ID after load, and HI/LO access during an in-flight multi-cycle mult/div.
- Drives PC/IF_ID write enables and bubble/flush controls.
- Owns the mult/div busy countdown.

Parameters:
- MUL_LATENCY, 4, EX cycles a mult occupies the mult/div unit (>=1).
- DIV_LATENCY, 32, EX cycles a div occupies the mult/div unit (>=MUL_LATENCY).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- IF_ID_rs, IF_ID_rt  in  5 each  source registers of the instruction in ID.
- IF_ID_uses_rs, IF_ID_uses_rt  in  1 each  ID instruction actually reads rs/rt.
- IF_ID_is_branch  in  1  ID instruction is beq/bne (resolved in ID).
- IF_ID_uses_hilo  in  1  ID instruction is mfhi/mflo/mult/div.
- branch_taken  in  1  ID branch comparator result.
- ID_EX_rd  in  5  destination of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_MEM_rd  in  5  destination of the instruction in MEM.
- EX_MEM_MemRead  in  1  instruction in MEM is a load.
- md_start  in  1  mult/div in EX this cycle (single-cycle pulse).
- md_is_div  in  1  qualifies md_start: 1=div, 0=mult.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Flush  out  1  insert bubble into ID/EX.
- IF_ID_Flush  out  1  squash the fetched instruction.
- md_busy  out  1  mult/div counter nonzero.
- stall  out  1  composite stall indication.

Behaviour:
- Register-0 rule: r0 never matches in any hazard compare.
- Load-use hazard, lu: ID_EX_MemRead && ID_EX_rd!=0 && ((uses_rs && ID_EX_rd==IF_ID_rs) || (uses_rt && ID_EX_rd==IF_ID_rt)).
- Branch-load hazard, bl: IF_ID_is_branch && EX_MEM_MemRead && EX_MEM_rd!=0 && EX_MEM_rd matches a used source. A branch directly behind a load therefore stalls 2 cycles (lu, then bl).
- HI/LO hazard, hl: IF_ID_uses_hilo && md_busy.
- stall = lu | bl | hl, combinational, same cycle.
- When stall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
- When stall=0: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0.
- IF_ID_Flush = branch_taken && !stall. A taken branch evaluated under stall uses stale operands and is ignored.
- Counter md_cnt is registered:
  - On md_start, loads (md_is_div ? DIV_LATENCY : MUL_LATENCY) - 1.
  - Otherwise it decrements while nonzero.
  - md_busy = (md_cnt != 0).
  - md_start while busy reloads the counter (last start wins). This cannot occur legally because hl stalls it.
  - md_start with latency 1 loads 0, so the unit is never busy.
- Counter width is $clog2(DIV_LATENCY+1).
- Reset (async assert, sync release by clk):
  - md_cnt=0.
  - While rst=1 outputs are forced: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=1, stall=1, md_busy=0.
  - Reset mid-mult/div aborts the count.
- Simultaneous lu and hl give a single stall; no priority is visible.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments on each clk with stall=1.
  - flush_count increments on each IF_ID_Flush=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Package pipeline_pkg holds:
  - REG_ZERO = 5'd0.
  - Default MUL/DIV latencies.
  - Forwarding select encodings (FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10), shared with the forwarding unit.
- One sub-module, md_busy_counter: parameterised load/decrement counter with async active-high reset, exposing busy.

Test Plan:
- lw r5 in EX (ID_EX_MemRead=1, ID_EX_rd=5), add r6,r5,r1 in ID (rs=5, uses_rs=1) -> stall=1, PC_Write=0, ID_EX_Flush=1 for exactly 1 cycle.
- lw r7 then beq r7,r0 in ID -> stall for 2 consecutive cycles (lu then bl). On cycle 3, branch_taken=1 -> IF_ID_Flush=1 for 1 cycle.
- ID_EX_rd=0 with MemRead=1 and IF_ID_rs=0 -> stall=0. IF_ID_rt=5 with uses_rt=0 against load rd=5 -> stall=0.
- md_start with md_is_div=1 and mfhi held in ID:
  - md_busy=1 for 31 cycles and stall=1 throughout.
  - stall drops on the cycle md_cnt reaches 0.
  - Repeat with a mult: 3 busy cycles.
- branch_taken=1 coincident with lu -> IF_ID_Flush=0 and stall=1. The next cycle with no hazard and branch_taken=1 -> IF_ID_Flush=1.
- rst asserted asynchronously mid-div (md_cnt=20) -> md_busy=0 immediately and PC_Write=0. After release with no hazards -> PC_Write=1. With HAZARD_PERF_EN: counters read 0 after reset and then count matching stall cycles.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and helpers for the hazard and forwarding units.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MUL_LATENCY_DEF = 4;
  localparam int DIV_LATENCY_DEF = 32;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // True when rd is a real register feeding one of the used sources.
  function automatic logic src_match(
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (rd != REG_ZERO) &&
           ((use_rs && (rd == rs)) ||
            (use_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Load/decrement occupancy counter for the multi-cycle mult/div unit.
module md_busy_counter
  import pipeline_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  localparam int CW = $clog2(DIV_LATENCY + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam logic [CW-1:0] MUL_LOAD =
    CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LOAD =
    CW'(DIV_LATENCY - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A new start always reloads, even mid-count.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = is_div_i ? DIV_LOAD : MUL_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush control: load-use, branch-after-load and HI/LO-busy hazards.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_count counters.
module hazard_detection_unit
  import pipeline_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic       IF_ID_uses_rs,
  input  logic       IF_ID_uses_rt,
  input  logic       IF_ID_is_branch,
  input  logic       IF_ID_uses_hilo,
  input  logic       branch_taken,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] EX_MEM_rd,
  input  logic       EX_MEM_MemRead,
  input  logic       md_start,
  input  logic       md_is_div,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Flush,
  output logic       IF_ID_Flush,
  output logic       md_busy,
  output logic       stall
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  logic cnt_busy;
  logic lu;
  logic bl;
  logic hl;
  logic hz;

  md_busy_counter #(
    .MUL_LATENCY(MUL_LATENCY),
    .DIV_LATENCY(DIV_LATENCY)
  ) u_md_cnt (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .is_div_i(md_is_div),
    .busy_o  (cnt_busy)
  );

  assign md_busy = cnt_busy & ~rst;

  assign lu = ID_EX_MemRead &&
    src_match(ID_EX_rd, IF_ID_rs, IF_ID_rt,
              IF_ID_uses_rs, IF_ID_uses_rt);

  assign bl = IF_ID_is_branch && EX_MEM_MemRead &&
    src_match(EX_MEM_rd, IF_ID_rs, IF_ID_rt,
              IF_ID_uses_rs, IF_ID_uses_rt);

  assign hl = IF_ID_uses_hilo && md_busy;
  assign hz = lu | bl | hl;

  // Reset holds the front end frozen and squashes both stage registers.
  assign stall       = rst | hz;
  assign PC_Write    = ~stall;
  assign IF_ID_Write = ~stall;
  assign ID_EX_Flush = stall;
  assign IF_ID_Flush = rst | (branch_taken & ~hz);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] stall_cyc_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cyc_q != '1)) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
    if (IF_ID_Flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cyc_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit (vectors, sequences, random).
module tb_hazard_detection_unit;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk;
  logic       rst;
  logic [4:0] IF_ID_rs;
  logic [4:0] IF_ID_rt;
  logic       IF_ID_uses_rs;
  logic       IF_ID_uses_rt;
  logic       IF_ID_is_branch;
  logic       IF_ID_uses_hilo;
  logic       branch_taken;
  logic [4:0] ID_EX_rd;
  logic       ID_EX_MemRead;
  logic [4:0] EX_MEM_rd;
  logic       EX_MEM_MemRead;
  logic       md_start;
  logic       md_is_div;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       ID_EX_Flush;
  logic       IF_ID_Flush;
  logic       md_busy;
  logic       stall;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  hazard_detection_unit #(
    .MUL_LATENCY(MUL_LAT),
    .DIV_LATENCY(DIV_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .IF_ID_uses_rs  (IF_ID_uses_rs),
    .IF_ID_uses_rt  (IF_ID_uses_rt),
    .IF_ID_is_branch(IF_ID_is_branch),
    .IF_ID_uses_hilo(IF_ID_uses_hilo),
    .branch_taken   (branch_taken),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .EX_MEM_rd      (EX_MEM_rd),
    .EX_MEM_MemRead (EX_MEM_MemRead),
    .md_start       (md_start),
    .md_is_div      (md_is_div),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .ID_EX_Flush    (ID_EX_Flush),
    .IF_ID_Flush    (IF_ID_Flush),
    .md_busy        (md_busy),
    .stall          (stall)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: busy while cycle index < busy_end.
  int cyc = 0;
  int busy_end = 0;
  logic [31:0] stall_m = 0;
  logic [31:0] flush_m = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       hilo;
    logic       tkn;
    logic [4:0] exrd;
    logic       exmr;
    logic [4:0] memrd;
    logic       memmr;
    logic       e_stall;
    logic       e_flush;
  } vec_t;

  vec_t vt[12];

  function automatic void chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endfunction

  function automatic void chk32(string nm, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endfunction

  function automatic logic hit(logic [4:0] rd);
    if (rd == 5'd0) return 1'b0;
    return (IF_ID_uses_rs && rd == IF_ID_rs) ||
           (IF_ID_uses_rt && rd == IF_ID_rt);
  endfunction

  function automatic void model(output logic s, output logic f,
                                output logic b);
    logic lu;
    logic bl;
    logic hl;
    b  = (cyc < busy_end);
    lu = ID_EX_MemRead && hit(ID_EX_rd);
    bl = IF_ID_is_branch && EX_MEM_MemRead && hit(EX_MEM_rd);
    hl = IF_ID_uses_hilo && b;
    s  = lu || bl || hl;
    f  = branch_taken && !s;
  endfunction

  task automatic idle();
    IF_ID_rs        = 5'd0;
    IF_ID_rt        = 5'd0;
    IF_ID_uses_rs   = 1'b0;
    IF_ID_uses_rt   = 1'b0;
    IF_ID_is_branch = 1'b0;
    IF_ID_uses_hilo = 1'b0;
    branch_taken    = 1'b0;
    ID_EX_rd        = 5'd0;
    ID_EX_MemRead   = 1'b0;
    EX_MEM_rd       = 5'd0;
    EX_MEM_MemRead  = 1'b0;
    md_start        = 1'b0;
    md_is_div       = 1'b0;
  endtask

  // Called at a negedge with inputs set; checks, then crosses one posedge.
  task automatic step(input string tag);
    logic s;
    logic f;
    logic b;
    #2;
    model(s, f, b);
    chk1({tag, ".stall"}, stall, s);
    chk1({tag, ".pcw"}, PC_Write, !s);
    chk1({tag, ".ifidw"}, IF_ID_Write, !s);
    chk1({tag, ".idexfl"}, ID_EX_Flush, s);
    chk1({tag, ".ifidfl"}, IF_ID_Flush, f);
    chk1({tag, ".busy"}, md_busy, b);
`ifdef HAZARD_PERF_EN
    chk32({tag, ".stcyc"}, stall_cycles, stall_m);
    chk32({tag, ".flcnt"}, flush_count, flush_m);
`endif
    @(posedge clk);
    if (md_start) busy_end = cyc + (md_is_div ? DIV_LAT : MUL_LAT);
    cyc++;
    if (s) stall_m++;
    if (f) flush_m++;
    @(negedge clk);
  endtask

  task automatic check_reset_forced(input string tag);
    chk1({tag, ".pcw"}, PC_Write, 1'b0);
    chk1({tag, ".ifidw"}, IF_ID_Write, 1'b0);
    chk1({tag, ".idexfl"}, ID_EX_Flush, 1'b1);
    chk1({tag, ".ifidfl"}, IF_ID_Flush, 1'b1);
    chk1({tag, ".stall"}, stall, 1'b1);
    chk1({tag, ".busy"}, md_busy, 1'b0);
`ifdef HAZARD_PERF_EN
    chk32({tag, ".stcyc"}, stall_cycles, 32'd0);
    chk32({tag, ".flcnt"}, flush_count, 32'd0);
`endif
  endtask

  int n;

  initial begin
    // rs rt urs urt br hilo tkn exrd exmr memrd memmr stall flush
    vt[0]  = '{5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
               5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
               5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
               5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
               5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
               5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{5'd3, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
               5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0};

    idle();
    rst = 1'b1;
    #3;
    check_reset_forced("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors (mult/div idle)
    for (int i = 0; i < 12; i++) begin
      IF_ID_rs        = vt[i].rs;
      IF_ID_rt        = vt[i].rt;
      IF_ID_uses_rs   = vt[i].urs;
      IF_ID_uses_rt   = vt[i].urt;
      IF_ID_is_branch = vt[i].br;
      IF_ID_uses_hilo = vt[i].hilo;
      branch_taken    = vt[i].tkn;
      ID_EX_rd        = vt[i].exrd;
      ID_EX_MemRead   = vt[i].exmr;
      EX_MEM_rd       = vt[i].memrd;
      EX_MEM_MemRead  = vt[i].memmr;
      #2;
      chk1($sformatf("vec%0d.stall", i), stall, vt[i].e_stall);
      chk1($sformatf("vec%0d.pcw", i), PC_Write, !vt[i].e_stall);
      chk1($sformatf("vec%0d.ifidfl", i), IF_ID_Flush, vt[i].e_flush);
      #1;
      step($sformatf("vec%0d", i));
    end

    // lw r7 ; beq r7,r0 : lu, then bl, then the branch resolves
    idle();
    IF_ID_rs = 5'd7; IF_ID_uses_rs = 1'b1; IF_ID_uses_rt = 1'b1;
    IF_ID_is_branch = 1'b1; branch_taken = 1'b1;
    ID_EX_rd = 5'd7; ID_EX_MemRead = 1'b1;
    #1; chk1("lb.c1.stall", stall, 1'b1);
    chk1("lb.c1.ifidfl", IF_ID_Flush, 1'b0);
    step("lb.c1");
    ID_EX_rd = 5'd0; ID_EX_MemRead = 1'b0;
    EX_MEM_rd = 5'd7; EX_MEM_MemRead = 1'b1;
    #1; chk1("lb.c2.stall", stall, 1'b1);
    chk1("lb.c2.ifidfl", IF_ID_Flush, 1'b0);
    step("lb.c2");
    EX_MEM_rd = 5'd0; EX_MEM_MemRead = 1'b0;
    #1; chk1("lb.c3.stall", stall, 1'b0);
    chk1("lb.c3.ifidfl", IF_ID_Flush, 1'b1);
    step("lb.c3");

    // div then mfhi held in ID
    idle();
    md_start = 1'b1; md_is_div = 1'b1; IF_ID_uses_hilo = 1'b1;
    step("div.start");
    md_start = 1'b0; md_is_div = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!md_busy) break;
      if (!stall) begin
        errors++;
        $display("FAIL div.hl_stall cycle %0d stall 0 want 1", n);
      end
      n++;
      step("div.busy");
    end
    chk32("div.busy_cycles", n, DIV_LAT - 1);
    step("div.done");

    // mult then mfhi
    md_start = 1'b1;
    step("mul.start");
    md_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!md_busy) break;
      n++;
      step("mul.busy");
    end
    chk32("mul.busy_cycles", n, MUL_LAT - 1);
    step("mul.done");

    // Async reset mid-div with count at 20
    idle();
    md_start = 1'b1; md_is_div = 1'b1;
    step("rdiv.start");
    md_start = 1'b0; md_is_div = 1'b0;
    for (int i = 0; i < 11; i++) step("rdiv.run");
    #2;
    chk1("rdiv.busy_before", md_busy, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_forced("rdiv.rst");
    @(negedge clk);
    check_reset_forced("rdiv.hold");
    busy_end = 0;
    stall_m  = 0;
    flush_m  = 0;
    rst = 1'b0;
    IF_ID_uses_hilo = 1'b1;
    #1; chk1("rdiv.after.pcw", PC_Write, 1'b1);
    step("rdiv.after");
    step("rdiv.after2");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      IF_ID_rs        = 5'($urandom_range(0, 3));
      IF_ID_rt        = 5'($urandom_range(0, 3));
      IF_ID_uses_rs   = 1'($urandom);
      IF_ID_uses_rt   = 1'($urandom);
      IF_ID_is_branch = 1'($urandom);
      IF_ID_uses_hilo = 1'($urandom);
      branch_taken    = 1'($urandom);
      ID_EX_rd        = 5'($urandom_range(0, 3));
      ID_EX_MemRead   = 1'($urandom);
      EX_MEM_rd       = 5'($urandom_range(0, 3));
      EX_MEM_MemRead  = 1'($urandom);
      md_start        = ($urandom_range(0, 19) == 0);
      md_is_div       = 1'($urandom);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
